serial_frame_scheduler: RTL and testbench

//  Sequences the 8N1 serial transmitter (char/send/busy handshake) to stream periodic

---
 rtl/serial_frame_pkg.sv | 23 ++
 rtl/period_timer.sv | 35 +++
 rtl/serial_frame_scheduler.sv | 167 ++++++++++++++++
 tb/tb_serial_frame_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Purpose : shared types and helpers for the serial frame scheduler.
// Contents: state_t  - frame sequencer states
//           SYNC_DEFAULT - frame start byte
//           frame_bytes  - frame length in bytes (SYNC + payload + checksum)
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        REQ  = 3'd2,
        WAIT = 3'd3,
        NEXT = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // SYNC byte + all counter bytes + checksum byte
    function automatic int unsigned frame_bytes(input int unsigned n_ch,
                                                input int unsigned cnt_w);
        return 2 + (n_ch * cnt_w) / 8;
    endfunction

endpackage

// File: rtl/period_timer.sv
// Purpose : free-running interval timer producing a one-cycle tick every PERIOD cycles.
// Ports   : clk       - clock
//           rst       - synchronous active-high reset
//           i_enable  - 1 = count; 0 = counter held at zero
//           o_tick_c  - combinational tick, high while the count sits at PERIOD-1
module period_timer #(
    parameter int unsigned PERIOD = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    output logic o_tick_c
);

    localparam int unsigned CW = $clog2(PERIOD);

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == CW'(PERIOD - 1));

    // Count 0..PERIOD-1 and wrap; disabling clears the count on the next edge
    always_ff @(posedge clk) begin
        if (rst || !i_enable) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tick_c = i_enable && w_last;

endmodule

// File: rtl/serial_frame_scheduler.sv
// Purpose : every PERIOD cycles snapshot N_CH counters and stream one frame
//           (SYNC, counter bytes MSB-first from ch0, XOR checksum) through the
//           8N1 transmitter's char/send/busy handshake.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           enable            - runs the period timer
//           cnt_flat          - live counts, ch k at [k*CNT_W +: CNT_W]
//           tx_char, tx_send  - byte and send request to the transmitter
//           tx_busy           - transmitter busy
//           frame_active      - high from snapshot until the last byte completes
//           overrun           - one-cycle pulse when a tick is dropped mid-frame
module serial_frame_scheduler
    import serial_frame_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned PERIOD = 50_000_000,
    parameter logic [7:0]  SYNC   = SYNC_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [N_CH*CNT_W-1:0]   cnt_flat,
    output logic [7:0]              tx_char,
    output logic                    tx_send,
    input  logic                    tx_busy,
    output logic                    frame_active,
    output logic                    overrun
);

    localparam int unsigned NB    = frame_bytes(N_CH, CNT_W);
    localparam int unsigned NPB   = NB - 2;
    localparam int unsigned BPC   = CNT_W / 8;
    localparam int unsigned IDX_W = $clog2(NB);

    state_t                  r_state, w_state_next;
    logic [N_CH*CNT_W-1:0]   r_snap;
    logic [IDX_W-1:0]        r_byte_idx, w_byte_idx_next, w_idx_inc;
    logic [7:0]              r_chk, w_chk_next;
    logic [7:0]              r_tx_char, w_tx_char_next;
    logic                    r_tx_send, w_tx_send_next;
    logic                    r_frame_active, w_frame_active_next;
    logic                    r_overrun;
    logic                    w_tick;
    logic [7:0]              w_payload [NPB];
    logic [7:0]              w_pay_sel;

    period_timer #(
        .PERIOD   (PERIOD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_enable (enable),
        .o_tick_c (w_tick)
    );

    // Payload byte j: channel j/BPC, byte j%BPC counted from the MSB
    for (genvar j = 0; j < NPB; j++) begin : g_pay
        localparam int unsigned CH = j / BPC;
        localparam int unsigned BY = j % BPC;
        assign w_payload[j] = r_snap[CH*CNT_W + (BPC-1-BY)*8 +: 8];
    end

    assign w_idx_inc = r_byte_idx + IDX_W'(1);

    // Payload byte for the frame index about to be requested (idx 1..NB-2)
    always_comb begin
        w_pay_sel = 8'h00;
        for (int j = 0; j < int'(NPB); j++) begin
            if (w_idx_inc == IDX_W'(j + 1)) begin
                w_pay_sel = w_payload[j];
            end
        end
    end

    // Snapshot is captured only in LOAD, one cycle after the tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap <= '0;
        end else if (r_state == LOAD) begin
            r_snap <= cnt_flat;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_byte_idx     <= '0;
            r_chk          <= 8'h00;
            r_tx_char      <= 8'h00;
            r_tx_send      <= 1'b0;
            r_frame_active <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_byte_idx     <= w_byte_idx_next;
            r_chk          <= w_chk_next;
            r_tx_char      <= w_tx_char_next;
            r_tx_send      <= w_tx_send_next;
            r_frame_active <= w_frame_active_next;
            r_overrun      <= w_tick && (r_state != IDLE);
        end
    end

    // Next state; send/char are computed one step ahead so they register
    // on the same edge the FSM enters REQ
    always_comb begin
        w_state_next        = r_state;
        w_byte_idx_next     = r_byte_idx;
        w_chk_next          = r_chk;
        w_tx_char_next      = r_tx_char;
        w_tx_send_next      = r_tx_send;
        w_frame_active_next = r_frame_active;

        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_state_next        = REQ;
                w_byte_idx_next     = '0;
                w_chk_next          = 8'h00;
                w_frame_active_next = 1'b1;
                w_tx_char_next      = SYNC;
                w_tx_send_next      = 1'b1;
            end
            REQ: begin
                if (tx_busy) begin
                    w_state_next   = WAIT;
                    w_tx_send_next = 1'b0;
                end
            end
            WAIT: begin
                if (!tx_busy) begin
                    w_state_next = NEXT;
                end
            end
            NEXT: begin
                if (r_byte_idx == IDX_W'(NB - 1)) begin
                    w_state_next        = IDLE;
                    w_frame_active_next = 1'b0;
                end else begin
                    w_state_next    = REQ;
                    w_byte_idx_next = w_idx_inc;
                    w_tx_send_next  = 1'b1;
                    if (w_idx_inc == IDX_W'(NB - 1)) begin
                        w_tx_char_next = r_chk;
                    end else begin
                        w_tx_char_next = w_pay_sel;
                        w_chk_next     = r_chk ^ w_pay_sel;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign tx_char      = r_tx_char;
    assign tx_send      = r_tx_send;
    assign frame_active = r_frame_active;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Purpose : directed self-checking bench for serial_frame_scheduler
//           (N_CH=2, CNT_W=16, PERIOD=200) with a handshaking TX model.
module tb_serial_frame_scheduler;

    localparam int unsigned N_CH   = 2;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PERIOD = 200;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic [N_CH*CNT_W-1:0] cnt_flat;
    logic [7:0]            tx_char;
    logic                  tx_send;
    logic                  tx_busy;
    logic                  frame_active;
    logic                  overrun;

    int checks   = 0;
    int failures = 0;

    int rise_cyc = 1;
    int hold_cyc = 10;

    logic [7:0] byte_log [$];
    int         m_st  = 0;
    int         m_cnt = 0;

    int   ovr_cnt  = 0;
    int   fa_rise  = 0;
    logic fa_prev  = 1'b0;

    serial_frame_scheduler #(
        .N_CH   (N_CH),
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD),
        .SYNC   (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cnt_flat     (cnt_flat),
        .tx_char      (tx_char),
        .tx_send      (tx_send),
        .tx_busy      (tx_busy),
        .frame_active (frame_active),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Transmitter: accepts a byte when idle and send=1, busy visible rise_cyc
    // cycles after send, held for hold_cyc cycles
    always @(posedge clk) begin
        if (rst) begin
            m_st    <= 0;
            m_cnt   <= 0;
            tx_busy <= 1'b0;
        end else begin
            case (m_st)
                0: if (tx_send === 1'b1) begin
                    byte_log.push_back(tx_char);
                    if (rise_cyc <= 1) begin
                        tx_busy <= 1'b1;
                        m_cnt   <= hold_cyc - 1;
                        m_st    <= 2;
                    end else begin
                        m_cnt <= rise_cyc - 2;
                        m_st  <= 1;
                    end
                end
                1: if (m_cnt == 0) begin
                    tx_busy <= 1'b1;
                    m_cnt   <= hold_cyc - 1;
                    m_st    <= 2;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                2: if (m_cnt == 0) begin
                    tx_busy <= 1'b0;
                    m_st    <= 0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                default: m_st <= 0;
            endcase
        end
    end

    // Overrun high-cycle count and frame_active rising-edge count
    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (frame_active === 1'b1 && fa_prev !== 1'b1) fa_rise++;
        fa_prev = frame_active;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_send(input string tag, input int limit, output int n);
        bit to;
        n  = 0;
        to = 1'b1;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (tx_send === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        check({tag, "_timeout"}, 32'(to), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit to;
        int n;
        n  = 0;
        to = 1'b1;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (frame_active === 1'b0 && tx_busy === 1'b0) begin
                to = 1'b0;
                break;
            end
        end
        check({tag, "_timeout"}, 32'(to), 32'd0);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [47:0] exp);
        logic [7:0] obs;
        check({tag, "_len"}, 32'(byte_log.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) begin
            obs = (base + i < byte_log.size()) ? byte_log[base + i] : 8'hxx;
            check($sformatf("%s_b%0d", tag, i), 32'(obs), 32'(exp[47 - 8*i -: 8]));
        end
    endtask

    initial begin
        int   n;
        int   base;
        int   c;
        int   w;
        int   s_ovr;
        int   s_fa;
        int   s_sz;
        bit   seen_low;
        bit   to;

        rst      = 1'b1;
        enable   = 1'b0;
        cnt_flat = {16'hABCD, 16'h1234};
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx_send",      32'(tx_send),      32'd0);
        check("rst_tx_char",      32'(tx_char),      32'd0);
        check("rst_frame_active", 32'(frame_active), 32'd0);
        check("rst_overrun",      32'(overrun),      32'd0);
        check("rst_timer",        32'(dut.u_timer.r_count), 32'd0);

        // 1: basic frame, latency from enable to first send
        rst    = 1'b0;
        enable = 1'b1;
        base   = byte_log.size();
        wait_send("t1_start", 400, n);
        check("t1_latency", 32'(n), 32'd201);
        check("t1_frame_active", 32'(frame_active), 32'd1);
        wait_done("t1_done", 1000);
        check_frame("t1", base, 48'hA5_1234_ABCD_40);

        // 2: counts change right after snapshot
        cnt_flat = {16'h0F0F, 16'h5AC3};
        base     = byte_log.size();
        wait_send("t2_start", 400, n);
        cnt_flat = {16'hFFFF, 16'hFFFF};
        wait_done("t2_done", 1000);
        check_frame("t2", base, 48'hA5_5AC3_0F0F_99);
        check("t2_no_overrun", 32'(ovr_cnt), 32'd0);

        // 3: frame longer than PERIOD -> one dropped tick per frame
        hold_cyc = 40;
        base     = byte_log.size();
        wait_send("t3_start", 400, n);
        s_ovr    = ovr_cnt;
        c        = 0;
        seen_low = 1'b0;
        while (c < 1000) begin
            @(negedge clk);
            c++;
            if (frame_active === 1'b0) seen_low = 1'b1;
            if (seen_low && frame_active === 1'b1) break;
        end
        check("t3_next_frame_spacing", 32'(c), 32'd400);
        check("t3_overrun_pulses", 32'(ovr_cnt - s_ovr), 32'd1);
        check_frame("t3a", base, 48'hA5_FFFF_FFFF_00);
        wait_done("t3b_done", 2000);
        hold_cyc = 10;
        s_ovr    = ovr_cnt;

        // 4: reset during WAIT of byte 3
        cnt_flat = {16'h8000, 16'h0001};
        base     = byte_log.size();
        wait_send("t4_start", 600, n);
        c  = 0;
        to = 1'b1;
        while (c < 1000) begin
            @(negedge clk);
            c++;
            if (byte_log.size() - base == 4 && tx_busy === 1'b1 && tx_send === 1'b0) begin
                to = 1'b0;
                break;
            end
        end
        check("t4_wait_byte3_timeout", 32'(to), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_tx_send",      32'(tx_send),      32'd0);
        check("t4_rst_frame_active", 32'(frame_active), 32'd0);
        check("t4_rst_timer",        32'(dut.u_timer.r_count), 32'd0);
        check("t4_rst_tx_char",      32'(tx_char),      32'd0);
        rst = 1'b0;
        check("t4_partial_len", 32'(byte_log.size() - base), 32'd4);
        base = byte_log.size();
        wait_send("t4_restart", 400, n);
        check("t4_restart_latency", 32'(n), 32'd201);
        wait_done("t4_done", 1000);
        check_frame("t4", base, 48'hA5_0001_8000_81);

        // 5: disable mid-frame, frame completes, no further frames
        cnt_flat = {16'h7E80, 16'h00FF};
        base     = byte_log.size();
        wait_send("t5_start", 400, n);
        c = 0;
        while (c < 200 && byte_log.size() - base < 2) begin
            @(negedge clk);
            c++;
        end
        enable = 1'b0;
        wait_done("t5_done", 1000);
        check_frame("t5", base, 48'hA5_00FF_7E80_01);
        s_sz = byte_log.size();
        s_fa = fa_rise;
        repeat (500) @(negedge clk);
        check("t5_idle_bytes",  32'(byte_log.size() - s_sz), 32'd0);
        check("t5_idle_frames", 32'(fa_rise - s_fa),         32'd0);
        enable = 1'b1;
        base   = byte_log.size();
        wait_send("t5_reenable", 400, n);
        check("t5_reenable_latency", 32'(n), 32'd201);
        wait_done("t5b_done", 1000);
        check_frame("t5b", base, 48'hA5_00FF_7E80_01);

        // 6: slow busy rise -> send held until busy, no duplicates
        rise_cyc = 5;
        cnt_flat = {16'h1357, 16'hC0DE};
        base     = byte_log.size();
        wait_send("t6_start", 400, n);
        w = 1;
        while (w < 50) begin
            @(negedge clk);
            if (tx_send === 1'b1) w++;
            else break;
        end
        check("t6_send_width", 32'(w), 32'd6);
        wait_done("t6_done", 1500);
        check_frame("t6", base, 48'hA5_C0DE_1357_5A);
        check("t6_no_overrun_since_t3", 32'(ovr_cnt - s_ovr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
